// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants
package alu_pkg;

   localparam int DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } div_state_e;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rcs.sv
// rtl/rcs.sv - combinational ripple-carry subtractor, diff = a - b
module rcs #(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   logic [WIDTH:0] c;

   // a + ~b + 1: carry-in of one completes the two's complement of b
   assign c[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a   (a[i]),
         .b   (~b[i]),
         .cin (c[i]),
         .s   (diff[i]),
         .cout(c[i+1])
      );
   end

   assign borrow = ~c[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per cycle
module seq_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   div_state_e       state;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   rshift;
   logic [WIDTH:0]   t;
   logic             borrow;
   logic [WIDTH-1:0] next_r;
   logic [WIDTH-1:0] next_q;
   logic             unused_t_msb;

   assign rshift = {r, q[WIDTH-1]};

   rcs #(.WIDTH(WIDTH + 1)) u_rcs (
      .a     (rshift),
      .b     ({1'b0, d}),
      .diff  (t),
      .borrow(borrow)
   );

   // A successful trial leaves t < d, so its top bit is always zero
   assign next_r       = borrow ? rshift[WIDTH-1:0] : t[WIDTH-1:0];
   assign next_q       = {q[WIDTH-2:0], ~borrow};
   assign unused_t_msb = t[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ready       <= 1'b1;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ready <= 1'b0;
                  if (divisor == '0) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state       <= RUN;
                     div_by_zero <= 1'b0;
                     r           <= '0;
                     q           <= dividend;
                     d           <= divisor;
                     cnt         <= '0;
                  end
               end
            end
            RUN: begin
               r <= next_r;
               q <= next_q;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  state     <= DONE;
                  done      <= 1'b1;
                  quotient  <= next_q;
                  remainder <= next_r;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        ready;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .ready      (ready),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   // Drives one start and returns the cycle done rose in (0 = never within budget)
   task automatic launch(input logic [15:0] dd, input logic [15:0] dv, output int dcyc);
      @(negedge clk);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(posedge clk);
      #1;
      start = 1'b0;
      dcyc  = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            dcyc = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (quotient !== 16'h0) begin errors++; $display("FAIL reset_quotient: got %h want 0000", quotient); end
      checks++; if (remainder !== 16'h0) begin errors++; $display("FAIL reset_remainder: got %h want 0000", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int dc;
      launch(16'd100, 16'd7, dc);
      checks++; if (dc !== 17) begin errors++; $display("FAIL basic_latency: got %0d want 17", dc); end
      checks++; if (quotient !== 16'd14) begin errors++; $display("FAIL basic_quotient: got %0d want 14", quotient); end
      checks++; if (remainder !== 16'd2) begin errors++; $display("FAIL basic_remainder: got %0d want 2", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_with_done: got %b want 0", ready); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_return: got %b want 1", ready); end
      repeat (3) @(negedge clk);
      checks++; if (quotient !== 16'd14 || remainder !== 16'd2) begin
         errors++; $display("FAIL basic_hold: got %0d r %0d want 14 r 2", quotient, remainder);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] dd [4] = '{16'hFFFF, 16'hFFFF, 16'd3, 16'd0};
      logic [15:0] dv [4] = '{16'd1, 16'hFFFF, 16'd10, 16'd5};
      logic [15:0] eq [4] = '{16'hFFFF, 16'd1, 16'd0, 16'd0};
      logic [15:0] er [4] = '{16'd0, 16'd0, 16'd3, 16'd0};
      int dc;
      for (int i = 0; i < 4; i++) begin
         launch(dd[i], dv[i], dc);
         checks++; if (dc !== 17) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want 17", i, dc); end
         checks++; if (quotient !== eq[i]) begin errors++; $display("FAIL b2b_quotient[%0d]: got %h want %h", i, quotient, eq[i]); end
         checks++; if (remainder !== er[i]) begin errors++; $display("FAIL b2b_remainder[%0d]: got %h want %h", i, remainder, er[i]); end
      end
   endtask

   task automatic test_div_zero();
      int dc;
      launch(16'd5, 16'd0, dc);
      checks++; if (dc !== 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", dc); end
      checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_quotient: got %h want ffff", quotient); end
      checks++; if (remainder !== 16'd5) begin errors++; $display("FAIL dz_remainder: got %0d want 5", remainder); end
      checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
      @(negedge clk);
      checks++; if (ready !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL dz_ready_return: got ready=%b done=%b want ready=1 done=0", ready, done);
      end
      repeat (2) @(negedge clk);
      checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_hold: got %b want 1", div_by_zero); end
      launch(16'd100, 16'd7, dc);
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_clear: got %b want 0", div_by_zero); end
      checks++; if (quotient !== 16'd14 || remainder !== 16'd2) begin
         errors++; $display("FAIL dz_next_result: got %0d r %0d want 14 r 2", quotient, remainder);
      end
      @(negedge clk);
   endtask

   task automatic test_ignored_start();
      int first_done = 0;
      int ndone = 0;
      logic [15:0] cq = '0;
      logic [15:0] cr = '0;
      @(negedge clk);
      start    = 1'b1;
      dividend = 16'd100;
      divisor  = 16'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            ndone++;
            if (first_done == 0) begin
               first_done = c;
               cq = quotient;
               cr = remainder;
            end
         end
         if (c == 3 || c == 10) begin
            start    = 1'b1;
            dividend = 16'd9;
            divisor  = 16'd2;
         end
      end
      start = 1'b0;
      checks++; if (first_done !== 17) begin errors++; $display("FAIL ign_latency: got %0d want 17", first_done); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", ndone); end
      checks++; if (cq !== 16'd14 || cr !== 16'd2) begin
         errors++; $display("FAIL ign_result: got %0d r %0d want 14 r 2", cq, cr);
      end
   endtask

   task automatic test_reset_midop();
      int dc;
      @(negedge clk);
      start    = 1'b1;
      dividend = 16'd100;
      divisor  = 16'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (ready !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL rst_mid_ctrl: got ready=%b done=%b want ready=1 done=0", ready, done);
      end
      checks++; if (quotient !== 16'h0 || remainder !== 16'h0 || div_by_zero !== 1'b0) begin
         errors++; $display("FAIL rst_mid_outputs: got q=%h r=%h dz=%b want 0", quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst = 1'b0;
      launch(16'd50, 16'd6, dc);
      checks++; if (dc !== 17) begin errors++; $display("FAIL rst_next_latency: got %0d want 17", dc); end
      checks++; if (quotient !== 16'd8 || remainder !== 16'd2) begin
         errors++; $display("FAIL rst_next_result: got %0d r %0d want 8 r 2", quotient, remainder);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_ignored_start();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
